updown_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 13 +
 rtl/updown_digit.sv | 41 ++++
 rtl/updown_timer.sv | 139 +++++++++++++
 tb/tb_updown_timer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the up/down minute:second:millisecond timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam int MS_MAX  = 999;
  localparam int SEC_MAX = 59;

  function automatic int unsigned clamp(input int unsigned value, input int unsigned limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/updown_digit.sv
// One wrapping counter digit (ms, sec or min) that steps up or down and
// reports the wrap so the next digit can carry/borrow.
module updown_digit #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VALUE);

  logic at_edge;

  // next_value is the value after this cycle's step, ignoring load; the top
  // level uses it to detect the edge on which the end value is reached.
  always_comb begin
    at_edge    = dir ? (value == '0) : (value == TOP);
    next_value = value;
    if (step) begin
      if (dir) next_value = at_edge ? TOP : value - WIDTH'(1);
      else     next_value = at_edge ? '0  : value + WIDTH'(1);
    end
  end

  assign wrap = step & at_edge;

  always_ff @(posedge clk) begin
    if (rst)       value <= '0;
    else if (load) value <= load_value;
    else           value <= next_value;
  end

endmodule

// File: rtl/updown_timer.sv
// Minute/second/millisecond timer counting down to zero or up to a loaded
// target, with pause/resume and a clock-rate-derived millisecond prescaler.
module updown_timer import timer_pkg::*; #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int MAX_MINUTE  = 59,
  parameter int MIN_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [7:0]       load_sec,
  input  logic [11:0]      load_ms,
  input  logic             dir,
  input  logic             start,
  input  logic             pause,
  output logic [MIN_W-1:0] minute,
  output logic [7:0]       second,
  output logic [11:0]      milli_second,
  output logic             running,
  output logic             expired,
  output logic             finish
);

  localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  state_t           state, state_next;
  logic [PS_W-1:0]  prescaler, prescaler_next;
  logic             finish_next;
  logic             dir_q;
  logic [MIN_W-1:0] target_min, clamp_min, end_min, min_next;
  logic [7:0]       target_sec, clamp_sec, end_sec, sec_next;
  logic [11:0]      target_ms, clamp_ms, end_ms, ms_next;
  logic             step, ms_wrap, sec_wrap, unused_min_wrap;
  logic             at_end, reach_end;

  assign clamp_min = MIN_W'(clamp(32'(load_min), 32'(MAX_MINUTE)));
  assign clamp_sec = 8'(clamp(32'(load_sec), 32'(SEC_MAX)));
  assign clamp_ms  = 12'(clamp(32'(load_ms), 32'(MS_MAX)));

  // End value: zero when counting down, the loaded target when counting up.
  assign end_min = dir_q ? '0 : target_min;
  assign end_sec = dir_q ? '0 : target_sec;
  assign end_ms  = dir_q ? '0 : target_ms;

  assign at_end    = {minute, second, milli_second} == {end_min, end_sec, end_ms};
  assign reach_end = {min_next, sec_next, ms_next} == {end_min, end_sec, end_ms};

  // A millisecond step happens on the edge where the prescaler wraps; load and
  // pause both suppress it.
  assign step = (state == RUN) && !load && !pause && (prescaler == PS_LAST);

  updown_digit #(.WIDTH(12), .MAX_VALUE(MS_MAX)) u_ms (
    .clk(clk), .rst(rst), .step(step), .dir(dir_q), .load(load),
    .load_value(dir ? clamp_ms : '0),
    .value(milli_second), .next_value(ms_next), .wrap(ms_wrap)
  );

  updown_digit #(.WIDTH(8), .MAX_VALUE(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .step(ms_wrap), .dir(dir_q), .load(load),
    .load_value(dir ? clamp_sec : '0),
    .value(second), .next_value(sec_next), .wrap(sec_wrap)
  );

  updown_digit #(.WIDTH(MIN_W), .MAX_VALUE(MAX_MINUTE)) u_min (
    .clk(clk), .rst(rst), .step(sec_wrap), .dir(dir_q), .load(load),
    .load_value(dir ? clamp_min : '0),
    .value(minute), .next_value(min_next), .wrap(unused_min_wrap)
  );

  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    finish_next    = 1'b0;
    if (load) begin
      state_next     = IDLE;
      prescaler_next = '0;
    end else begin
      case (state)
        IDLE, PAUSED: begin
          if (!pause && start) begin
            if (at_end) begin
              state_next  = DONE;
              finish_next = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          // Pause holds the prescaler so resume keeps the sub-millisecond phase.
          if (pause) begin
            state_next = PAUSED;
          end else if (step) begin
            prescaler_next = '0;
            if (reach_end) begin
              state_next  = DONE;
              finish_next = 1'b1;
            end
          end else begin
            prescaler_next = prescaler + PS_W'(1);
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prescaler  <= '0;
      dir_q      <= 1'b1;
      target_min <= '0;
      target_sec <= '0;
      target_ms  <= '0;
      running    <= 1'b0;
      expired    <= 1'b0;
      finish     <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      if (load) begin
        dir_q      <= dir;
        target_min <= clamp_min;
        target_sec <= clamp_sec;
        target_ms  <= clamp_ms;
      end
      running <= (state_next == RUN);
      expired <= (state_next == DONE);
      finish  <= finish_next;
    end
  end

endmodule

// File: tb/tb_updown_timer.sv
// Bench for updown_timer at DIV=4: table of load vectors plus scripted
// count, pause, expiry and reset sequences checked through a scoreboard.
module tb_updown_timer;

  logic        clk;
  logic        rst;
  logic        load;
  logic [7:0]  load_min;
  logic [7:0]  load_sec;
  logic [11:0] load_ms;
  logic        dir;
  logic        start;
  logic        pause;
  logic [7:0]  minute;
  logic [7:0]  second;
  logic [11:0] milli_second;
  logic        running;
  logic        expired;
  logic        finish;

  int total = 0;
  int bad   = 0;

  logic [30:0] exp_q[$];
  string       name_q[$];

  updown_timer #(
    .CLK_FREQ_HZ(4000), .TICK_HZ(1000), .MAX_MINUTE(59), .MIN_W(8)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .load_min(load_min), .load_sec(load_sec),
    .load_ms(load_ms), .dir(dir), .start(start), .pause(pause),
    .minute(minute), .second(second), .milli_second(milli_second),
    .running(running), .expired(expired), .finish(finish)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected record from a total millisecond count and the three flags.
  function automatic logic [30:0] pack(input int t, input logic r, input logic x, input logic f);
    logic [7:0]  m;
    logic [7:0]  s;
    logic [11:0] ms;
    m  = 8'(t / 60000);
    s  = 8'((t / 1000) % 60);
    ms = 12'(t % 1000);
    return {m, s, ms, r, x, f};
  endfunction

  // driver: one clock with the currently driven inputs; expectation is for
  // the outputs after that edge
  task automatic cyc(input string nm, input int t, input logic r, input logic x, input logic f);
    @(posedge clk);
    #1;
    exp_q.push_back(pack(t, r, x, f));
    name_q.push_back(nm);
  endtask

  task automatic do_load(input string nm, input logic d, input int m, input int s,
                         input int ms, input int exp_t);
    dir      = d;
    load_min = 8'(m);
    load_sec = 8'(s);
    load_ms  = 12'(ms);
    load     = 1'b1;
    cyc(nm, exp_t, 1'b0, 1'b0, 1'b0);
    load     = 1'b0;
  endtask

  // Independent model of a run: one tick every 4 cycles after the start edge,
  // stopping at n_end ticks; finish only on the expiry edge.
  task automatic run_expect(input string nm, input int base, input bit dn,
                            input int n_end, input int cycles);
    for (int c = 1; c <= cycles; c++) begin
      int tk;
      bit done;
      tk = c / 4;
      if (tk > n_end) tk = n_end;
      done = (tk == n_end);
      cyc(nm, dn ? base - tk : tk, !done, done, done && (c == 4 * n_end));
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [30:0] e;
      logic [30:0] g;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = {minute, second, milli_second, running, expired, finish};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s @%0t: got %0d:%0d.%0d run=%b exp=%b fin=%b, want %0d:%0d.%0d run=%b exp=%b fin=%b",
                 nm, $time, g[30:23], g[22:15], g[14:3], g[2], g[1], g[0],
                 e[30:23], e[22:15], e[14:3], e[2], e[1], e[0]);
      end
    end
  end

  typedef struct {
    logic d;
    int   m;
    int   s;
    int   ms;
    int   exp_t;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 0, 0, 5, 5};
    vecs[1] = '{1'b1, 70, 75, 1500, 3599999};
    vecs[2] = '{1'b1, 2, 30, 400, 150400};
    vecs[3] = '{1'b0, 5, 5, 5, 0};
    vecs[4] = '{1'b1, 59, 59, 999, 3599999};
    vecs[5] = '{1'b1, 60, 59, 999, 3599999};
    vecs[6] = '{1'b1, 0, 60, 0, 59000};
    vecs[7] = '{1'b1, 0, 0, 1000, 999};

    rst = 1'b1; load = 1'b0; dir = 1'b0; start = 1'b0; pause = 1'b0;
    load_min = '0; load_sec = '0; load_ms = '0;

    cyc("reset", 0, 0, 0, 0);
    cyc("reset", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (20) cyc("reset_idle", 0, 0, 0, 0);

    // load/clamp vectors
    for (int i = 0; i < 8; i++) begin
      do_load("load_vec", vecs[i].d, vecs[i].m, vecs[i].s, vecs[i].ms, vecs[i].exp_t);
      cyc("load_vec_hold", vecs[i].exp_t, 0, 0, 0);
    end

    // count down 5 ms, then start/pause in DONE are ignored
    do_load("dn5_load", 1'b1, 0, 0, 5, 5);
    start = 1'b1; cyc("dn5_start", 5, 1, 0, 0); start = 1'b0;
    run_expect("dn5_run", 5, 1'b1, 5, 23);
    start = 1'b1; cyc("done_start", 0, 0, 1, 0); start = 1'b0;
    pause = 1'b1; cyc("done_pause", 0, 0, 1, 0); pause = 1'b0;

    // 1 s down: borrow from seconds on the first tick, expire after 1000 ticks
    do_load("dn1s_load", 1'b1, 0, 1, 0, 1000);
    start = 1'b1; cyc("dn1s_start", 1000, 1, 0, 0); start = 1'b0;
    run_expect("dn1s_run", 1000, 1'b1, 1000, 4003);

    // count up to 3 ms
    do_load("up3_load", 1'b0, 0, 0, 3, 0);
    start = 1'b1; cyc("up3_start", 0, 1, 0, 0); start = 1'b0;
    run_expect("up3_run", 0, 1'b0, 3, 14);

    // count up across a seconds carry
    do_load("up1001_load", 1'b0, 0, 1, 1, 0);
    start = 1'b1; cyc("up1001_start", 0, 1, 0, 0); start = 1'b0;
    run_expect("up1001_run", 0, 1'b0, 1001, 4006);

    // borrow from minutes, then reload mid-run
    do_load("minb_load", 1'b1, 1, 0, 0, 60000);
    start = 1'b1; cyc("minb_start", 60000, 1, 0, 0); start = 1'b0;
    run_expect("minb_run", 60000, 1'b1, 60000, 8);

    // pause after 2 prescaler cycles keeps the phase across the resume
    do_load("pause_load", 1'b1, 0, 0, 10, 10);
    start = 1'b1; cyc("pause_start", 10, 1, 0, 0); start = 1'b0;
    cyc("pre_pause", 10, 1, 0, 0);
    cyc("pre_pause", 10, 1, 0, 0);
    pause = 1'b1;
    repeat (17) cyc("paused", 10, 0, 0, 0);
    pause = 1'b0;
    start = 1'b1; cyc("resume", 10, 1, 0, 0); start = 1'b0;
    cyc("resume1", 10, 1, 0, 0);
    cyc("resume2", 9, 1, 0, 0);
    repeat (3) cyc("resume_hold", 9, 1, 0, 0);
    cyc("resume6", 8, 1, 0, 0);

    // load on the expiry edge wins and suppresses finish
    do_load("lx_load", 1'b1, 0, 0, 2, 2);
    start = 1'b1; cyc("lx_start", 2, 1, 0, 0); start = 1'b0;
    run_expect("lx_run", 2, 1'b1, 2, 7);
    do_load("load_on_expiry", 1'b1, 0, 0, 7, 7);
    cyc("lx_no_finish", 7, 0, 0, 0);
    repeat (4) cyc("lx_idle_hold", 7, 0, 0, 0);

    // zero target counting down: immediate finish on start
    do_load("zero_load", 1'b1, 0, 0, 0, 0);
    start = 1'b1; cyc("zero_start", 0, 0, 1, 1); start = 1'b0;
    cyc("zero_after", 0, 0, 1, 0);

    // reset mid-count overrides start on the same edge
    do_load("rst_load", 1'b1, 0, 0, 9, 9);
    start = 1'b1; cyc("rst_start", 9, 1, 0, 0); start = 1'b0;
    run_expect("rst_run", 9, 1'b1, 9, 6);
    rst = 1'b1; start = 1'b1;
    cyc("rst_mid", 0, 0, 0, 0);
    rst = 1'b0; start = 1'b0;
    cyc("post_rst", 0, 0, 0, 0);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
